// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller and its loop-detector front end.
package traffic_pkg;

    localparam int unsigned DIR_N   = 0;
    localparam int unsigned DIR_E   = 1;
    localparam int unsigned DIR_S   = 2;
    localparam int unsigned DIR_W   = 3;
    localparam int unsigned NUM_DIR = 4;

    localparam int unsigned TICK_HZ          = 1;
    localparam int unsigned DEB_LEN_DEF      = 3;
    localparam int unsigned STUCK_TICKS_DEF  = 120;

endpackage

// File: rtl/sensor_channel.sv
// One inductive-loop channel: synchroniser, tick-paced debouncer, demand latch,
// saturating arrival counter and stuck-loop detector.
module sensor_channel
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_LEN     = DEB_LEN_DEF,
    parameter int unsigned STUCK_TICKS = STUCK_TICKS_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             loop_raw,
    input  logic             green,
    input  logic             clr_cnt,
    output logic             sensor,
    output logic             fault,
    output logic [CNT_W-1:0] veh_cnt
);

    localparam int unsigned DW = $clog2(DEB_LEN);
    localparam int unsigned SW = $clog2(STUCK_TICKS + 1);

    logic             sync1_q, sync2_q;
    logic             pres_q, pres_d;
    logic             pres_dly_q;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    stk_q, stk_d;
    logic             demand_q, demand_d;
    logic             fault_q, fault_d;
    logic             sensor_q, sensor_d;
    logic             rise;

    always_comb begin
        pres_d    = pres_q;
        deb_cnt_d = deb_cnt_q;
        if (tick) begin
            if (sync2_q == pres_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DW'(DEB_LEN - 1)) begin
                pres_d    = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        rise  = pres_q & ~pres_dly_q;
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (rise && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        stk_d = stk_q;
        if (!pres_q) begin
            stk_d = '0;
        end else if (tick && stk_q != SW'(STUCK_TICKS)) begin
            stk_d = stk_q + 1'b1;
        end

        // Presence wins over green so a queued vehicle keeps its demand.
        demand_d = pres_q | (demand_q & ~green);
        fault_d  = pres_q & (stk_q == SW'(STUCK_TICKS));
        sensor_d = demand_d | fault_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pres_q     <= 1'b0;
            pres_dly_q <= 1'b0;
            deb_cnt_q  <= '0;
            cnt_q      <= '0;
            stk_q      <= '0;
            demand_q   <= 1'b0;
            fault_q    <= 1'b0;
            sensor_q   <= 1'b0;
        end else begin
            sync1_q    <= loop_raw;
            sync2_q    <= sync1_q;
            pres_q     <= pres_d;
            pres_dly_q <= pres_q;
            deb_cnt_q  <= deb_cnt_d;
            cnt_q      <= cnt_d;
            stk_q      <= stk_d;
            demand_q   <= demand_d;
            fault_q    <= fault_d;
            sensor_q   <= sensor_d;
        end
    end

    assign sensor  = sensor_q;
    assign fault   = fault_q;
    assign veh_cnt = cnt_q;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Four identical loop-detector channels feeding the intersection controller's
// sensor inputs; this level only fans buses out and back in.
module vehicle_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_LEN     = DEB_LEN_DEF,
    parameter int unsigned STUCK_TICKS = STUCK_TICKS_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [NUM_DIR-1:0]         loop_raw,
    input  logic [NUM_DIR-1:0]         green,
    input  logic                       clr_cnt,
    output logic                       sensor_north,
    output logic                       sensor_east,
    output logic                       sensor_south,
    output logic                       sensor_west,
    output logic [NUM_DIR-1:0]         fault,
    output logic [NUM_DIR*CNT_W-1:0]   veh_cnt
);

    logic [NUM_DIR-1:0] sensor_vec;

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_chan
        sensor_channel #(
            .DEB_LEN     (DEB_LEN),
            .STUCK_TICKS (STUCK_TICKS),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .loop_raw (loop_raw[i]),
            .green    (green[i]),
            .clr_cnt  (clr_cnt),
            .sensor   (sensor_vec[i]),
            .fault    (fault[i]),
            .veh_cnt  (veh_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign sensor_north = sensor_vec[DIR_N];
    assign sensor_east  = sensor_vec[DIR_E];
    assign sensor_south = sensor_vec[DIR_S];
    assign sensor_west  = sensor_vec[DIR_W];

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the loop-conditioning rules.
module tb_vehicle_sensor_conditioner;

    localparam int DEB = 3;
    localparam int STK = 120;
    localparam int CW  = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic [3:0]      loop_raw;
    logic [3:0]      green;
    logic            clr_cnt;
    logic            sn, se, ss, sw;
    logic [3:0]      fault;
    logic [4*CW-1:0] veh_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: synchroniser stages, debounced presence, consecutive
    // disagreeing-tick run, last presence, counts, demand, stuck ticks, outputs.
    int m_s1[4], m_s2[4], m_pres[4], m_run[4], m_prev[4];
    int m_cnt[4], m_dem[4], m_stk[4], m_flt[4], m_sen[4];

    vehicle_sensor_conditioner #(
        .DEB_LEN     (DEB),
        .STUCK_TICKS (STK),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .loop_raw     (loop_raw),
        .green        (green),
        .clr_cnt      (clr_cnt),
        .sensor_north (sn),
        .sensor_east  (se),
        .sensor_south (ss),
        .sensor_west  (sw),
        .fault        (fault),
        .veh_cnt      (veh_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_pres[i] = 0; m_run[i] = 0; m_prev[i] = 0;
            m_cnt[i] = 0; m_dem[i] = 0; m_stk[i] = 0; m_flt[i] = 0; m_sen[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int pres_now = m_pres[i];
            int n_pres   = m_pres[i];
            int n_run    = m_run[i];
            int n_cnt    = m_cnt[i];
            int n_dem, n_flt, n_stk;
            if (tick) begin
                // Presence follows the loop only after DEB agreeing ticks in a row.
                n_run = (m_s2[i] != m_pres[i]) ? m_run[i] + 1 : 0;
                if (n_run == DEB) begin
                    n_pres = m_s2[i];
                    n_run  = 0;
                end
            end
            if (clr_cnt) n_cnt = 0;
            else if (pres_now == 1 && m_prev[i] == 0) n_cnt = (m_cnt[i] < MAXC) ? m_cnt[i] + 1 : MAXC;
            if (pres_now == 1) n_dem = 1;
            else if (green[i]) n_dem = 0;
            else n_dem = m_dem[i];
            n_flt = (pres_now == 1 && m_stk[i] == STK) ? 1 : 0;
            if (pres_now == 0) n_stk = 0;
            else if (tick) n_stk = (m_stk[i] < STK) ? m_stk[i] + 1 : STK;
            else n_stk = m_stk[i];
            m_s2[i]   = m_s1[i];
            m_s1[i]   = loop_raw[i] ? 1 : 0;
            m_prev[i] = pres_now;
            m_pres[i] = n_pres;
            m_run[i]  = n_run;
            m_cnt[i]  = n_cnt;
            m_dem[i]  = n_dem;
            m_flt[i]  = n_flt;
            m_stk[i]  = n_stk;
            m_sen[i]  = (n_dem | n_flt);
        end
    endtask

    task automatic compare_all();
        logic [3:0]      es, ef;
        logic [4*CW-1:0] ec;
        for (int i = 0; i < 4; i++) begin
            es[i] = (m_sen[i] != 0);
            ef[i] = (m_flt[i] != 0);
            ec[i*CW +: CW] = CW'(m_cnt[i]);
        end
        check("sensor", {28'd0, sw, ss, se, sn}, {28'd0, es});
        check("fault", {28'd0, fault}, {28'd0, ef});
        check("veh_cnt", veh_cnt, ec);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_outputs", {24'd0, fault, sw, ss, se, sn}, 32'd0);
        check("rst_veh_cnt", veh_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; tick = 1'b0; loop_raw = '0; green = '0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        tick = 1'b1;

        // North arrival latency: 2 sync clk + 3 ticks + 1 clk.
        loop_raw[0] = 1'b1;
        cycles(5);
        check("n_latency_early", {31'd0, sn}, 32'd0);
        cyc();
        check("n_latency_on", {31'd0, sn}, 32'd1);
        cycles(3);
        check("n_veh_cnt", {24'd0, veh_cnt[7:0]}, 32'd1);
        check("n_others_quiet", {29'd0, sw, ss, se}, 32'd0);

        // Two-tick east glitch must be rejected.
        seen = 1'b0;
        loop_raw[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) loop_raw[1] = 1'b0;
            cyc();
            seen |= se;
        end
        check("e_glitch_sensor", {31'd0, seen}, 32'd0);
        check("e_glitch_cnt", {24'd0, veh_cnt[15:8]}, 32'd0);

        // Demand survives loop release, clears on green; persists if loop still high.
        loop_raw[0] = 1'b0;
        cycles(8);
        check("n_demand_held", {31'd0, sn}, 32'd1);
        green[0] = 1'b1;
        cyc();
        green[0] = 1'b0;
        check("n_green_clear", {31'd0, sn}, 32'd0);
        loop_raw[0] = 1'b1;
        cycles(8);
        green[0] = 1'b1;
        cycles(5);
        check("n_green_present", {31'd0, sn}, 32'd1);
        green[0] = 1'b0;
        loop_raw[0] = 1'b0;
        cycles(8);
        green[0] = 1'b1;
        cyc();
        green[0] = 1'b0;

        // 300 south arrivals saturate, then clear coincident with an arrival.
        for (int k = 0; k < 300; k++) begin
            loop_raw[2] = 1'b1;
            cycles(6);
            loop_raw[2] = 1'b0;
            cycles(6);
        end
        check("s_saturate", {24'd0, veh_cnt[23:16]}, 32'd255);
        loop_raw[2] = 1'b1;
        cycles(5);
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        check("s_clr_wins", {24'd0, veh_cnt[23:16]}, 32'd0);
        loop_raw[2] = 1'b0;
        cycles(6);
        green[2] = 1'b1;
        cyc();
        green[2] = 1'b0;

        // West stuck loop: fault after 120 present ticks, drops with presence.
        loop_raw[3] = 1'b1;
        cycles(125);
        check("w_fault_early", {31'd0, fault[3]}, 32'd0);
        cyc();
        check("w_fault_on", {31'd0, fault[3]}, 32'd1);
        loop_raw[3] = 1'b0;
        cycles(5);
        check("w_fault_hold", {31'd0, fault[3]}, 32'd1);
        cyc();
        check("w_fault_off", {31'd0, fault[3]}, 32'd0);
        check("w_sensor_held", {31'd0, sw}, 32'd1);
        cycles(3);
        green[3] = 1'b1;
        cyc();
        green[3] = 1'b0;
        check("w_green_clear", {31'd0, sw}, 32'd0);

        // Reset mid-demand and mid-debounce; the next rise needs the full debounce.
        loop_raw[0] = 1'b1;
        cycles(8);
        loop_raw[0] = 1'b0;
        cycles(6);
        loop_raw[1] = 1'b1;
        cycles(4);
        do_reset();
        cycles(5);
        check("e_after_rst_early", {31'd0, se}, 32'd0);
        cyc();
        check("e_after_rst_on", {31'd0, se}, 32'd1);
        loop_raw[1] = 1'b0;
        cycles(8);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            tick = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) loop_raw[i] = ~loop_raw[i];
            green   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            clr_cnt = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Front-end stage feeding the 4-way traffic light controller's `sensor_north/east/south/west` inputs. It synchronises and debounces four raw inductive-loop detector signals and latches a per-approach demand until the controller has served that approach with green. It also counts vehicle arrivals per approach and flags stuck-on loops, forcing demand high on a faulted loop so the approach is never starved.

## Interface
Parameters:
- `DEB_LEN`, 3: consecutive `tick` samples of a new loop level required before the debounced presence changes (≥2).
- `STUCK_TICKS`, 120: consecutive ticks of debounced presence after which a loop is declared stuck.
- `CNT_W`, 8: width of each vehicle counter.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `tick`  in  1  one-clk sample strobe (1 Hz, same strobe that paces the controller)
- `loop_raw`  in  4  raw detector inputs, asynchronous; bit 0=N, 1=E, 2=S, 3=W
- `green`  in  4  approach currently green/yellow in controller (same bit order)
- `clr_cnt`  in  1  synchronous clear of all vehicle counters
- `sensor_north`, `sensor_east`, `sensor_south`, `sensor_west`  out  1 each  demand to controller
- `fault`  out  4  stuck-loop flag per approach
- `veh_cnt`  out  4*CNT_W  packed arrival counters; approach i at `[i*CNT_W +: CNT_W]`

## Operation
Per channel, all channels identical and independent:
- Synchroniser: 2-flop sync of `loop_raw[i]` on every clk.
- Debouncer: `pres` (debounced presence), `deb_cnt` (counter width ceil(log2(DEB_LEN))).
  - On a tick with sync == `pres`: `deb_cnt`←0.
  - On a tick with sync != `pres`: if `deb_cnt` == DEB_LEN-1, then `pres`←sync and `deb_cnt`←0; else `deb_cnt`++.
  - Non-tick cycles hold state.
- Edge detect: `pres_d` ← `pres` every clk; rise = `pres & ~pres_d`.
- Counter: on rise, `veh_cnt`++, saturating at 2^CNT_W-1. `clr_cnt` wins over increment.
- Demand latch, evaluated every clk:
  - Set when `pres` is 1.
  - Else clear when `green[i]` is 1.
  - Else hold.
  - Set has priority over clear.
- Stuck detector: `stk_cnt` increments on each tick while `pres`=1, saturating at STUCK_TICKS, and →0 when `pres`=0. `fault[i]` = (`stk_cnt` == STUCK_TICKS), registered. It self-clears when presence drops.
- Output: `sensor_x` = `demand | fault`, registered.

## Timing
- Reset values: all outputs 0; `pres`, `pres_d`, `demand`, sync flops, all counters 0.
- Loop-to-`pres` latency: 2 clk sync, plus DEB_LEN ticks, plus 0 clk (`pres` flips on the edge of the DEB_LEN-th qualifying tick).
- `pres` to `sensor_x`: 1 clk. `pres` to `veh_cnt` update: 1 clk.
- Glitch rejection: a change lasting fewer than DEB_LEN consecutive ticks never reaches `pres`; any tick that reverts to `pres` resets `deb_cnt`.
- Demand clear: `sensor_x` falls 1 clk after the first clk with `green[i]`=1 and `pres`=0. If a vehicle is still present, demand persists through green.
- Fault: `fault[i]` rises 1 clk after the STUCK_TICKS-th tick with `pres`=1. It falls 1 clk after `pres` falls, but `sensor_x` stays high until demand is cleared by green.
- Simultaneous `clr_cnt` and rise: counter = 0.
- Reset mid-debounce or mid-demand: immediate return to reset values. Pending demand is lost.

## Structure
- Shared package `traffic_pkg`: direction index constants `DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3`, `NUM_DIR=4`, tick-rate constant, default DEB_LEN/STUCK_TICKS.
- Sub-module `sensor_channel`: synchroniser + debouncer + demand + counter + stuck detector for one loop. Instantiated 4× by a generate loop; the top level only packs and unpacks buses.

## Test plan
- Reset, then `loop_raw[N]`=1 held: `sensor_north`=1 exactly 2 clk + 3 ticks + 1 clk after assertion; `veh_cnt[N]`=1; other sensors 0.
- Pulse `loop_raw[E]`=1 for 2 ticks then 0 (DEB_LEN=3): `sensor_east` never asserts; `veh_cnt[E]`=0.
- N demand latched, loop released and debounced low, then `green[0]`=1: `sensor_north` falls 1 clk later. Repeat with loop still high: `sensor_north` stays 1.
- 300 clean vehicle arrivals on S with CNT_W=8: `veh_cnt[S]` saturates at 255. `clr_cnt` asserted together with an arrival: `veh_cnt[S]`=0.
- `loop_raw[W]` held 1 for 120 ticks: `fault[3]`=1 after the 120th tick. Loop released: `fault[3]`→0 after debounce + 1 clk. `sensor_west` stays 1 until `green[3]`.
- Assert `rst` mid-debounce (2 ticks into a rise) and mid-latched demand: all outputs 0 immediately; the next rise requires the full 3 ticks.
